// File: rtl/fsm_sym_decoder.sv
// Symbol decoder: recovers bits from 3-chip symbols (110=1, 100=0), packs WORD_W-bit words; SYM_ERR_CNT_EN adds err_cnt/err_clr.
// Latency: word valid 1 cycle after its last stop chip; sym_err/overrun are registered one-cycle pulses.
// Backpressure: dout held while dout_valid && !dout_ready; a word completing then is dropped and flagged on overrun.
module fsm_sym_decoder #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sym_err,
  output logic              overrun
`ifdef SYM_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    DATA = 2'b01,
    STOP = 2'b10,
    ILL  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              bit_q;

  logic              good_sym;
  logic              bad_sym;
  logic              word_done;
  logic              drop;
  logic              load;
  logic [WORD_W-1:0] word_nxt;

  always_comb begin
    state_nxt = state;
    good_sym  = 1'b0;
    bad_sym   = 1'b0;
    case (state)
      HUNT: if (din) state_nxt = DATA;
      DATA: state_nxt = STOP;
      STOP: begin
        // The stop chip is consumed here; a high stop is never reused as a start.
        state_nxt = HUNT;
        if (din) bad_sym  = 1'b1;
        else     good_sym = 1'b1;
      end
      default: state_nxt = HUNT;
    endcase
    word_nxt  = {shreg[WORD_W-2:0], bit_q};
    word_done = good_sym && (bit_cnt == CW'(WORD_W - 1));
    drop      = word_done && dout_valid && !dout_ready;
    load      = word_done && !drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HUNT;
      shreg      <= '0;
      bit_cnt    <= '0;
      bit_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sym_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sym_err <= bad_sym;
      overrun <= drop;
      if (state == DATA) bit_q <= din;
      if (good_sym) begin
        shreg   <= word_nxt;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end else if (bad_sym) begin
        bit_cnt <= '0;
      end
      // A load on the handshake edge keeps valid high for the new word.
      if (load) begin
        dout       <= word_nxt;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SYM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= 8'h00;
    end else if (err_clr) begin
      err_cnt <= bad_sym ? 8'h01 : 8'h00;
    end else if (bad_sym && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_sym_decoder.sv
// Randomised scoreboard bench for fsm_sym_decoder: a bit-list/word-slot model predicts per-cycle flags and delivered words.
module tb_fsm_sym_decoder;

  localparam int W = 8;
  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_ERR  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         sym_err;
  logic         overrun;
`ifdef SYM_ERR_CNT_EN
  logic         err_clr = 1'b0;
  logic [7:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  fsm_sym_decoder #(.WORD_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sym_err    (sym_err),
    .overrun    (overrun)
`ifdef SYM_ERR_CNT_EN
    ,
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    int         cyc;
    logic       se;
    logic       ov;
    logic       vld;
    logic [7:0] ecnt;
  } rec_t;

  rec_t         rq[$];
  logic [W-1:0] wq[$];
  bit           bits[$];
  logic         slot_full = 1'b0;
  logic [7:0]   ecnt_m = 8'h00;
  int           rdy_pct = 100;
  logic         clr_v = 1'b0;
  int           cyc = 0;
  int           chk_cnt = 0;
  int           pass_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else pass_cnt++;
  endtask

  // One clock of stimulus; ev marks the chip that closes a symbol.
  task automatic step(input logic r, input logic d, input int ev, input bit b);
    rec_t e;
    logic rdy;
    logic full_before;
    int   acc;
    @(posedge clk);
    #2;
    rdy = ($urandom_range(99) < rdy_pct);
    rst = r;
    din = d;
    dout_ready = rdy;
`ifdef SYM_ERR_CNT_EN
    err_clr = clr_v;
`endif
    e.cyc = cyc + 1;
    e.se  = 1'b0;
    e.ov  = 1'b0;
    if (!r) begin
      bits.delete();
      wq.delete();
      slot_full = 1'b0;
      ecnt_m = 8'h00;
    end else begin
      full_before = slot_full;
      if (slot_full && rdy) slot_full = 1'b0;
      if (ev == EV_GOOD) begin
        bits.push_back(b);
        if (bits.size() == W) begin
          acc = 0;
          foreach (bits[i]) acc = acc * 2 + int'(bits[i]);
          bits.delete();
          if (full_before && !rdy) e.ov = 1'b1;
          else begin
            wq.push_back(acc[W-1:0]);
            slot_full = 1'b1;
          end
        end
      end else if (ev == EV_ERR) begin
        e.se = 1'b1;
        bits.delete();
      end
      if (clr_v) ecnt_m = (ev == EV_ERR) ? 8'h01 : 8'h00;
      else if (ev == EV_ERR && ecnt_m != 8'hFF) ecnt_m = ecnt_m + 8'h01;
    end
    e.vld  = slot_full;
    e.ecnt = ecnt_m;
    rq.push_back(e);
  endtask

  task automatic send_sym(input bit b, input bit bad);
    step(1'b1, 1'b1, EV_NONE, 1'b0);
    step(1'b1, b, EV_NONE, 1'b0);
    step(1'b1, bad, bad ? EV_ERR : EV_GOOD, b);
  endtask

  task automatic send_word(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) send_sym(v[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, EV_NONE, 1'b0);
  endtask

  // Monitor: flags every cycle, words on each handshake.
  initial begin
    rec_t e;
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      while (rq.size() > 0 && rq[0].cyc <= cyc) begin
        e = rq.pop_front();
        check("sym_err", sym_err, e.se);
        check("overrun", overrun, e.ov);
        check("dout_valid", dout_valid, e.vld);
`ifdef SYM_ERR_CNT_EN
        check("err_cnt", err_cnt, e.ecnt);
`endif
      end
      if (rst === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
        check("word_pending", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          check("dout", dout, w);
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, EV_NONE, 1'b0);
    step(1'b0, 1'b0, EV_NONE, 1'b0);
    rdy_pct = 100;
    send_word(8'hA5);
    idle(3);
    idle(10);
    send_word(8'h3C);
    idle(2);
    send_sym(1'b1, 1'b0);
    send_sym(1'b0, 1'b0);
    send_sym(1'b1, 1'b0);
    send_sym(1'b0, 1'b1);
    send_word(8'hFF);
    idle(2);
    rdy_pct = 0;
    send_word(8'h12);
    send_word(8'h34);
    idle(3);
    rdy_pct = 100;
    idle(1);
    rdy_pct = 0;
    idle(3);
    rdy_pct = 100;
    for (int i = 0; i < 5; i++) send_sym(1'b1, 1'b0);
    step(1'b0, 1'b0, EV_NONE, 1'b0);
    send_word(8'h81);
    idle(3);
    rdy_pct = 70;
    repeat (150) begin
      idle($urandom_range(0, 3));
      send_sym(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
`ifdef SYM_ERR_CNT_EN
    repeat (300) send_sym(1'($urandom_range(0, 1)), 1'b1);
    idle(2);
    clr_v = 1'b1;
    idle(1);
    clr_v = 1'b0;
    idle(2);
`endif
    rdy_pct = 100;
    idle(6);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", wq.size(), 0);
    check("records_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
